// File: rtl/riscv_pkg.sv
// Shared fetch/pre-decode types: pipeline control bundle, parcel-aligner states and
// RISC-V encoding constants.
package riscv_pkg;

   typedef struct packed {
      logic reset;
      logic stall;
      logic flush;
   } pipeline_ctrl_t;

   typedef enum logic [1:0] {
      ALIGNED = 2'd0,
      UPPER   = 2'd1,
      HALF    = 2'd2
   } align_state_e;

   localparam logic [1:0]  PARCEL_32B_MARK = 2'b11;
   localparam logic [31:0] NOP             = 32'h0000_0013;

   function automatic logic is_32b_parcel(input logic [15:0] parcel);
      return parcel[1:0] == PARCEL_32B_MARK;
   endfunction

endpackage

// File: rtl/fetch_align_perf_ctr.sv
// Saturating performance counters for the fetch parcel aligner: spanning emits and
// fetch bubbles. Only instantiated when FROST_FETCH_ALIGN_PERF_EN is defined.
module fetch_align_perf_ctr (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_span_inc,
   input  logic        i_bubble_inc,
   output logic [31:0] o_span_count,
   output logic [31:0] o_bubble_count
);

   logic [31:0] span_q, span_d;
   logic [31:0] bubble_q, bubble_d;

   always_comb begin
      span_d   = span_q;
      bubble_d = bubble_q;
      if (i_span_inc && (span_q != '1)) span_d = span_q + 32'd1;
      if (i_bubble_inc && (bubble_q != '1)) bubble_d = bubble_q + 32'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         span_q   <= '0;
         bubble_q <= '0;
      end else begin
         span_q   <= span_d;
         bubble_q <= bubble_d;
      end
   end

   assign o_span_count   = span_q;
   assign o_bubble_count = bubble_q;

endmodule

// File: rtl/fetch_parcel_align_ctrl.sv
// Fetch parcel sequencer: turns aligned 32-bit fetch words into one RVC/32-bit instr per
// cycle for pre-decode. Optional perf counters under FROST_FETCH_ALIGN_PERF_EN.
module fetch_parcel_align_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  pipeline_ctrl_t  i_pipeline_ctrl,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_fetch_valid,
   input  logic [31:0]     i_fetch_word,
   output logic            o_fetch_ready,
   output logic [XLEN-1:0] o_fetch_addr,
   output logic            o_sel_nop,
   output logic            o_sel_spanning,
   output logic            o_sel_compressed,
   output logic [15:0]     o_raw_parcel,
   output logic [31:0]     o_spanning_instr,
   output logic [31:0]     o_effective_instr,
   output logic [XLEN-1:0] o_program_counter,
   output logic [XLEN-1:0] o_link_address
`ifdef FROST_FETCH_ALIGN_PERF_EN
   ,
   output logic [31:0]     o_perf_span_count,
   output logic [31:0]     o_perf_bubble_count
`endif
);

   align_state_e    state_q, state_d;
   logic [15:0]     buf_q, buf_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            sel_nop_q, sel_nop_d;
   logic            sel_span_q, sel_span_d;
   logic            sel_comp_q, sel_comp_d;
   logic [15:0]     raw_q, raw_d;
   logic [31:0]     span_instr_q, span_instr_d;
   logic [31:0]     eff_q, eff_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic [XLEN-1:0] link_q, link_d;
   logic [XLEN-1:0] pc_plus2, pc_plus4;

   assign pc_plus2 = pc_q + XLEN'(2);
   assign pc_plus4 = pc_q + XLEN'(4);

   // In HALF the buffered parcel sits at pc, so the word wanted is the next one.
   assign o_fetch_addr = (state_q == HALF) ? ((pc_q & ~XLEN'(3)) + XLEN'(4))
                                           : (pc_q & ~XLEN'(3));

   // NOTE: every signal gets its hold value first so no path can infer a latch.
   always_comb begin
      o_fetch_ready = 1'b0;
      state_d       = state_q;
      buf_d         = buf_q;
      pc_d          = pc_q;
      sel_nop_d     = sel_nop_q;
      sel_span_d    = sel_span_q;
      sel_comp_d    = sel_comp_q;
      raw_d         = raw_q;
      span_instr_d  = span_instr_q;
      eff_d         = eff_q;
      pc_out_d      = pc_out_q;
      link_d        = link_q;

      if (i_pipeline_ctrl.reset) begin
         o_fetch_ready = 1'b0;
      end else if (i_redirect) begin
         pc_d       = i_redirect_pc & ~XLEN'(1);
         state_d    = i_redirect_pc[1] ? UPPER : ALIGNED;
         sel_nop_d  = 1'b1;
         sel_span_d = 1'b0;
         sel_comp_d = 1'b0;
      end else if (i_pipeline_ctrl.flush) begin
         sel_nop_d  = 1'b1;
         sel_span_d = 1'b0;
         sel_comp_d = 1'b0;
      end else if (!i_pipeline_ctrl.stall) begin
         sel_nop_d  = 1'b1;
         sel_span_d = 1'b0;
         sel_comp_d = 1'b0;
         unique case (state_q)
            ALIGNED: begin
               o_fetch_ready = 1'b1;
               if (i_fetch_valid) begin
                  sel_nop_d = 1'b0;
                  pc_out_d  = pc_q;
                  if (is_32b_parcel(i_fetch_word[15:0])) begin
                     eff_d  = i_fetch_word;
                     link_d = pc_plus4;
                     pc_d   = pc_plus4;
                  end else begin
                     sel_comp_d = 1'b1;
                     raw_d      = i_fetch_word[15:0];
                     link_d     = pc_plus2;
                     pc_d       = pc_plus2;
                     buf_d      = i_fetch_word[31:16];
                     state_d    = HALF;
                  end
               end
            end
            UPPER: begin
               o_fetch_ready = 1'b1;
               if (i_fetch_valid) begin
                  if (is_32b_parcel(i_fetch_word[31:16])) begin
                     buf_d   = i_fetch_word[31:16];
                     state_d = HALF;
                  end else begin
                     sel_nop_d  = 1'b0;
                     sel_comp_d = 1'b1;
                     raw_d      = i_fetch_word[31:16];
                     pc_out_d   = pc_q;
                     link_d     = pc_plus2;
                     pc_d       = pc_plus2;
                     state_d    = ALIGNED;
                  end
               end
            end
            HALF: begin
               if (!is_32b_parcel(buf_q)) begin
                  sel_nop_d  = 1'b0;
                  sel_comp_d = 1'b1;
                  raw_d      = buf_q;
                  pc_out_d   = pc_q;
                  link_d     = pc_plus2;
                  pc_d       = pc_plus2;
                  state_d    = ALIGNED;
               end else begin
                  o_fetch_ready = 1'b1;
                  if (i_fetch_valid) begin
                     sel_nop_d    = 1'b0;
                     sel_span_d   = 1'b1;
                     span_instr_d = {i_fetch_word[15:0], buf_q};
                     pc_out_d     = pc_q;
                     link_d       = pc_plus4;
                     pc_d         = pc_plus4;
                     buf_d        = i_fetch_word[31:16];
                  end
               end
            end
            default: state_d = ALIGNED;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge i_clk) begin
      if (i_pipeline_ctrl.reset) begin
         state_q      <= RESET_PC[1] ? UPPER : ALIGNED;
         pc_q         <= RESET_PC & ~XLEN'(1);
         buf_q        <= '0;
         sel_nop_q    <= 1'b1;
         sel_span_q   <= 1'b0;
         sel_comp_q   <= 1'b0;
         raw_q        <= '0;
         span_instr_q <= '0;
         eff_q        <= '0;
         pc_out_q     <= '0;
         link_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         sel_nop_q    <= sel_nop_d;
         sel_span_q   <= sel_span_d;
         sel_comp_q   <= sel_comp_d;
         raw_q        <= raw_d;
         span_instr_q <= span_instr_d;
         eff_q        <= eff_d;
         pc_out_q     <= pc_out_d;
         link_q       <= link_d;
      end
   end

   assign o_sel_nop         = sel_nop_q;
   assign o_sel_spanning    = sel_span_q;
   assign o_sel_compressed  = sel_comp_q;
   assign o_raw_parcel      = raw_q;
   assign o_spanning_instr  = span_instr_q;
   assign o_effective_instr = eff_q;
   assign o_program_counter = pc_out_q;
   assign o_link_address    = link_q;

`ifdef FROST_FETCH_ALIGN_PERF_EN
   logic normal_cycle;
   logic span_inc;
   logic bubble_inc;

   // Bubbles caused by reset, redirect or flush are not the aligner's fault.
   assign normal_cycle = !i_pipeline_ctrl.reset && !i_redirect &&
                         !i_pipeline_ctrl.flush && !i_pipeline_ctrl.stall;
   assign span_inc     = normal_cycle && sel_span_d;
   assign bubble_inc   = normal_cycle && sel_nop_d;

   fetch_align_perf_ctr u_perf_ctr (
      .i_clk          (i_clk),
      .i_reset        (i_pipeline_ctrl.reset),
      .i_span_inc     (span_inc),
      .i_bubble_inc   (bubble_inc),
      .o_span_count   (o_perf_span_count),
      .o_bubble_count (o_perf_bubble_count)
   );
`endif

endmodule
